spi_tx_arbiter: RTL and testbench
=================================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 SHALL have parameter DROP_W, default 8, width of the saturating overwrite counter.
REQ-002 SHALL have port clk  input  1  system clock; all logic is in this single clock domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  1  one-cycle pulse from the SPI slave at the start of a transaction, requesting the next frame.
REQ-005 SHALL have port src0_valid  input  1  tracker coordinate word available.
REQ-006 SHALL have port src0_data  input  30  tracker payload: x[9:0], y[18:10], flags[29:19].
REQ-007 SHALL have port src0_ready  output  1  high when the src0 holding register can accept a word.
REQ-008 SHALL have port src1_valid  input  1  status/telemetry word available.
REQ-009 SHALL have port src1_data  input  30  status payload.
REQ-010 SHALL have port src1_ready  output  1  high when the src1 holding register can accept a word.
REQ-011 SHALL have port data_frame  output  32  frame to the SPI packer: tag[31:30], payload[29:0].
REQ-012 SHALL have port frame_load  output  1  one-cycle pulse when data_frame changes.
REQ-013 SHALL have port drop_cnt  output  DROP_W  saturating count of src0 words overwritten before transmission.

Function
REQ-014 SHALL hold one holding register plus pending flag per source; a word is accepted on a cycle with valid && ready.
REQ-015 SHALL keep src1_ready = !pend1, so src1 is lossless and stalls while pending.
REQ-016 SHALL keep src0_ready = 1 always; src0 accepted while pend0=1 overwrites the held word and increments drop_cnt, saturating at all-ones.
REQ-017 SHALL implement FSM IDLE -> ARB -> LOAD -> IDLE: IDLE waits for req; ARB selects a source; LOAD updates data_frame, pulses frame_load and clears the chosen pending flag.
REQ-018 SHALL take req in IDLE to ARB on the next edge; data_frame and frame_load SHALL update 2 cycles after the req cycle.
REQ-019 SHALL ignore req pulses while in ARB or LOAD, and SHALL NOT queue them.
REQ-020 SHALL, in ARB, choose the only pending source when exactly one is pending.
REQ-021 SHALL, in ARB with both pending, choose round-robin, taking the source not selected last; last_sel SHALL reset to src1, so src0 wins first.
REQ-022 SHALL, in ARB with none pending, produce an empty frame as given by REQ-030/031; last_sel SHALL be unchanged.
REQ-023 SHALL use tags 01 for src0, 10 for src1, 00 for idle and 11 for stale.
REQ-024 SHALL, when an accept and a clear of the same source coincide in LOAD, clear the old word and set pending for the new word; the new word is not lost and is not counted as a drop.
REQ-025 SHALL hold data_frame stable outside LOAD, so it is constant for the whole SPI transaction.

Reset
REQ-026 SHALL, on reset assertion, immediately force state=IDLE, pend0=pend1=0, data_frame=32'h0, frame_load=0, drop_cnt=0 and last_sel=src1.
REQ-027 SHALL make src0_ready=1 and src1_ready=1 while reset is asserted.
REQ-028 SHALL, on reset mid-ARB/LOAD, abandon the transaction with no frame_load pulse and lose the held words.
REQ-029 SHALL accept req on the first clock edge after reset deassertion.

Configuration
REQ-030 SHALL, with macro SPI_ARB_HOLD_EN defined, make the empty case repeat the last transmitted payload with tag 11; if nothing has been sent since reset, the payload SHALL be 0.
REQ-031 SHALL, with SPI_ARB_HOLD_EN undefined, make the empty case load 32'h0 (tag 00); the hold register SHALL be absent.

Verification
REQ-032 SHALL cover this scenario: after reset, src0 sends 30'h0012345 then req at cycle n -> data_frame=32'h40012345 and frame_load pulses at n+2, then src0_ready=1.
REQ-033 SHALL cover this scenario: src0 and src1 both pending, three reqs -> tags 01, 10, then 00 (HOLD off) or 11 carrying the src1 payload (HOLD on).
REQ-034 SHALL cover this scenario: three src0 words with no req between them -> drop_cnt=2 and the frame carries the third word; 300 overwrites with DROP_W=8 -> drop_cnt=255.
REQ-035 SHALL cover this scenario: src1 pending and src1_valid held high -> src1_ready=0 until the LOAD cycle, and the accept on that cycle leaves pend1=1.
REQ-036 SHALL cover this scenario: req pulses at n and n+1 -> exactly one frame_load pulse.
REQ-037 SHALL cover this scenario: reset asserted in the LOAD cycle -> data_frame=0 and frame_load=0 without waiting for a clock edge, both pending flags cleared.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// Two-source frame arbiter feeding an SPI slave packer: src0 (tracker) is overwrite-on-full, src1 (status) is lossless.
// Define SPI_ARB_HOLD_EN to make empty frames repeat the last payload with the stale tag instead of sending zero.
module spi_tx_arbiter #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              src0_valid,
    input  logic [29:0]       src0_data,
    output logic              src0_ready,
    input  logic              src1_valid,
    input  logic [29:0]       src1_data,
    output logic              src1_ready,
    output logic [31:0]       data_frame,
    output logic              frame_load,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam logic [1:0] TAG_SRC0  = 2'b01;
    localparam logic [1:0] TAG_SRC1  = 2'b10;
`ifdef SPI_ARB_HOLD_EN
    localparam logic [1:0] TAG_STALE = 2'b11;
`endif

    state_t      state;
    logic [29:0] hold0;
    logic [29:0] hold1;
    logic        pend0;
    logic        pend1;
    logic        last_sel;
    logic        accept0;
    logic        accept1;
    logic        pick0;
    logic        pick1;
    logic [31:0] next_frame;
`ifdef SPI_ARB_HOLD_EN
    logic [29:0] last_payload;
`endif

    assign src0_ready = 1'b1;
    assign src1_ready = !pend1;
    assign accept0    = src0_valid;
    assign accept1    = src1_valid && !pend1;

    // last_sel: 0 = src0 went last, 1 = src1 went last; on a tie the other one wins.
    assign pick0 = (state == ARB) && pend0 && (!pend1 || last_sel);
    assign pick1 = (state == ARB) && pend1 && (!pend0 || !last_sel);

    always_comb begin
        next_frame = 32'h0;
        if (pick0) begin
            next_frame = {TAG_SRC0, hold0};
        end else if (pick1) begin
            next_frame = {TAG_SRC1, hold1};
        end else begin
`ifdef SPI_ARB_HOLD_EN
            next_frame = {TAG_STALE, last_payload};
`else
            next_frame = 32'h0;
`endif
        end
    end

    // A word arriving on the same edge its predecessor is handed to the frame becomes the new pending word, not a drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold0    <= 30'h0;
            hold1    <= 30'h0;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept0) begin
                hold0 <= src0_data;
                pend0 <= 1'b1;
                if (pend0 && !pick0 && (drop_cnt != {DROP_W{1'b1}})) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else if (pick0) begin
                pend0 <= 1'b0;
            end

            if (accept1) begin
                hold1 <= src1_data;
                pend1 <= 1'b1;
            end else if (pick1) begin
                pend1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            data_frame <= 32'h0;
            frame_load <= 1'b0;
            last_sel   <= 1'b1;
        end else begin
            frame_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    data_frame <= next_frame;
                    frame_load <= 1'b1;
                    state      <= LOAD;
                    if (pick0) begin
                        last_sel <= 1'b0;
                    end else if (pick1) begin
                        last_sel <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_ARB_HOLD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_payload <= 30'h0;
        end else if (pick0) begin
            last_payload <= hold0;
        end else if (pick1) begin
            last_payload <= hold1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Honours SPI_ARB_HOLD_EN the same way the design does.
module tb_spi_tx_arbiter;

    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              src0_valid = 1'b0;
    logic [29:0]       src0_data = 30'h0;
    logic              src0_ready;
    logic              src1_valid = 1'b0;
    logic [29:0]       src1_data = 30'h0;
    logic              src1_ready;
    logic [31:0]       data_frame;
    logic              frame_load;
    logic [DROP_W-1:0] drop_cnt;

    int errors = 0;
    int checks = 0;
    int load_pulses = 0;

    // Reference model: at most one waiting word per source, transaction phase counted in cycles since req.
    logic [29:0] q0[$];
    logic [29:0] q1[$];
    int          m_phase;
    int          m_last;
    int          m_drop;
    logic [31:0] m_frame;
    logic        m_load;
    logic [29:0] m_hold;

    spi_tx_arbiter #(.DROP_W(DROP_W)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .src0_valid(src0_valid),
        .src0_data(src0_data),
        .src0_ready(src0_ready),
        .src1_valid(src1_valid),
        .src1_data(src1_data),
        .src1_ready(src1_ready),
        .data_frame(data_frame),
        .frame_load(frame_load),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v0, input logic [29:0] d0,
                                 input logic v1, input logic [29:0] d1);
        req        = r;
        src0_valid = v0;
        src0_data  = d0;
        src1_valid = v1;
        src1_data  = d1;
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        m_phase = 0;
        m_last  = 1;
        m_drop  = 0;
        m_frame = 32'h0;
        m_load  = 1'b0;
        m_hold  = 30'h0;
    endtask

    task automatic modelStep();
        logic        room1;
        logic [29:0] w;
        room1  = (q1.size() == 0);
        m_load = 1'b0;
        if (m_phase == 1) begin
            m_load  = 1'b1;
            m_phase = 2;
            if (q0.size() != 0 && (q1.size() == 0 || m_last == 1)) begin
                w       = q0.pop_front();
                m_frame = {2'b01, w};
                m_hold  = w;
                m_last  = 0;
            end else if (q1.size() != 0) begin
                w       = q1.pop_front();
                m_frame = {2'b10, w};
                m_hold  = w;
                m_last  = 1;
            end else begin
`ifdef SPI_ARB_HOLD_EN
                m_frame = {2'b11, m_hold};
`else
                m_frame = 32'h0;
`endif
            end
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (req) begin
            m_phase = 1;
        end
        if (src0_valid) begin
            if (q0.size() != 0) begin
                if (m_drop < DROP_MAX) m_drop++;
                q0.delete();
            end
            q0.push_back(src0_data);
        end
        if (src1_valid && room1) q1.push_back(src1_data);
    endtask

    task automatic checkAll();
        checkOutput("data_frame", data_frame, m_frame);
        checkOutput("frame_load", 32'(frame_load), 32'(m_load));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        checkOutput("src0_ready", 32'(src0_ready), 32'd1);
        checkOutput("src1_ready", 32'(src1_ready), 32'(q1.size() == 0));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        #1;
        if (frame_load) load_pulses++;
        checkAll();
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 30'h0, 1'b0, 30'h0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAll();
        reset = 1'b0;
    endtask

    // One full transaction: req cycle, arbitration cycle, then stops inside the LOAD cycle.
    task automatic reqToLoad(input logic v0, input logic [29:0] d0, input logic v1, input logic [29:0] d1);
        applyStimulus(1'b1, v0, d0, v1, d1);
        stepCycle();
        applyStimulus(1'b0, v0, d0, v1, d1);
        stepCycle();
    endtask

    initial begin
        int pulses_before;
        modelReset();
        resetDut();
        $display("[TB] reset state checked");

        // src0 single word, frame appears two cycles after req
        applyStimulus(1'b0, 1'b1, 30'h0012345, 1'b0, 30'h0);
        stepCycle();
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("s1_frame", data_frame, 32'h40012345);
        checkOutput("s1_load", 32'(frame_load), 32'd1);
        stepCycle();
        checkOutput("s1_ready0", 32'(src0_ready), 32'd1);

        // both pending: round robin then empty
        resetDut();
        applyStimulus(1'b0, 1'b1, 30'h0AAAAAA, 1'b1, 30'h1555555);
        stepCycle();
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("s2_first", data_frame, 32'h40AAAAAA);
        stepCycle();
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("s2_second", data_frame, {2'b10, 30'h1555555});
        stepCycle();
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
`ifdef SPI_ARB_HOLD_EN
        checkOutput("s2_third", data_frame, {2'b11, 30'h1555555});
`else
        checkOutput("s2_third", data_frame, 32'h0);
`endif
        stepCycle();

        // overwrites and saturation
        resetDut();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b1, 30'(i * 30'h111), 1'b0, 30'h0);
            stepCycle();
        end
        checkOutput("s3_drop2", 32'(drop_cnt), 32'd2);
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("s3_frame", data_frame, {2'b01, 30'h333});
        stepCycle();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 30'($urandom), 1'b0, 30'h0);
            stepCycle();
        end
        checkOutput("s3_sat", 32'(drop_cnt), 32'd255);

        // src1 backpressure with valid held
        resetDut();
        applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 30'h0BEEF01);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 30'h0C0FFEE);
        stepCycle();
        checkOutput("s4_stall", 32'(src1_ready), 32'd0);
        reqToLoad(1'b0, 30'h0, 1'b1, 30'h0C0FFEE);
        checkOutput("s4_frame", data_frame, {2'b10, 30'h0BEEF01});
        checkOutput("s4_ready_load", 32'(src1_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 30'h0, 1'b1, 30'h0C0FFEE);
        stepCycle();
        checkOutput("s4_repend", 32'(src1_ready), 32'd0);
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("s4_next", data_frame, {2'b10, 30'h0C0FFEE});
        stepCycle();

        // back-to-back req pulses give a single load
        resetDut();
        pulses_before = load_pulses;
        applyStimulus(1'b1, 1'b1, 30'h0000042, 1'b0, 30'h0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 30'h0, 1'b0, 30'h0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 30'h0, 1'b0, 30'h0);
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("s5_pulses", 32'(load_pulses - pulses_before), 32'd1);

        // reset in the LOAD cycle takes effect without a clock edge
        resetDut();
        applyStimulus(1'b0, 1'b1, 30'h0001111, 1'b1, 30'h0002222);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 30'h0003333, 1'b0, 30'h0);
        stepCycle();
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("s6_in_load", 32'(frame_load), 32'd1);
        applyStimulus(1'b0, 1'b0, 30'h0, 1'b0, 30'h0);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("s6_frame", data_frame, 32'h0);
        checkOutput("s6_load", 32'(frame_load), 32'd0);
        checkOutput("s6_ready1", 32'(src1_ready), 32'd1);
        checkOutput("s6_drop", 32'(drop_cnt), 32'd0);
        #2;
        reset = 1'b0;
        reqToLoad(1'b0, 30'h0, 1'b0, 30'h0);
        checkOutput("s6_empty", 32'(data_frame[29:0]), 32'd0);
        stepCycle();

        // randomized traffic
        resetDut();
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(3) == 0), ($urandom_range(2) == 0), 30'($urandom),
                          ($urandom_range(2) == 0), 30'($urandom));
            stepCycle();
        end
        $display("[TB] random phase complete");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
